// File: rtl/mdio_master_22_45.sv
// MDIO station-management initiator for Clause 22 / Clause 45 frames.
// One command at a time: preamble, 32-bit frame, one idle tail period, then a response pulse.
module mdio_master_22_45 #(
    parameter int unsigned MDC_DIV = 10,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_cl45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    localparam int unsigned CW         = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;
    localparam int unsigned HALF       = MDC_DIV / 2;
    localparam int unsigned PRE_LAST   = (PRE_LEN == 0) ? 0 : PRE_LEN - 1;
    localparam int unsigned HDR_BITS   = 14;
    localparam int unsigned TA2_BIT    = 15;
    localparam int unsigned FRAME_LAST = 31;

    typedef enum logic [1:0] {IDLE, PRE, FRAME, TAIL} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    bit_q;
    logic [31:0]   sh_q;
    logic          rd_q;
    logic [15:0]   rx_q;
    logic          ta_err_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          mdc_q;
    logic          mdio_o_q;
    logic          mdio_oe_q;

    logic          illegal_c;
    logic          acc_rd_c;
    logic [31:0]   frame_c;
    logic          per_end_c;
    logic          mid_c;
    logic [CW-1:0] cnt_d;
    logic [5:0]    bit_d;
    logic          oe_d;

    // Decode of the presented command and bit-period timing
    always_comb begin
        illegal_c = 1'b0;
        acc_rd_c  = 1'b0;
        frame_c   = '0;
        illegal_c = !cmd_cl45 && ((cmd_op == 2'b00) || (cmd_op == 2'b11));
        acc_rd_c  = cmd_cl45 ? cmd_op[1] : (cmd_op == 2'b10);
        frame_c   = {(cmd_cl45 ? 2'b00 : 2'b01), cmd_op, cmd_phyad, cmd_regad,
                     (acc_rd_c ? 18'h3FFFF : {2'b10, cmd_wdata})};
        per_end_c = (cnt_q == CW'(MDC_DIV - 1));
        mid_c     = (cnt_q == CW'(HALF));
        cnt_d     = per_end_c ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q + 6'd1;
        oe_d      = !rd_q || (bit_d < 6'(HDR_BITS));
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            rd_q        <= 1'b0;
            rx_q        <= '0;
            ta_err_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (illegal_c) begin
                            // Rejected in place: answer next cycle, bus stays quiet
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            sh_q        <= frame_c;
                            rd_q        <= acc_rd_c;
                            rx_q        <= '0;
                            ta_err_q    <= 1'b0;
                            cnt_q       <= '0;
                            bit_q       <= '0;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            mdc_q       <= 1'b0;
                            mdio_oe_q   <= 1'b1;
                            if (PRE_LEN == 0) begin
                                state_q  <= FRAME;
                                mdio_o_q <= frame_c[31];
                            end else begin
                                state_q  <= PRE;
                                mdio_o_q <= 1'b1;
                            end
                        end
                    end
                end
                PRE: begin
                    cnt_q <= cnt_d;
                    mdc_q <= (cnt_d >= CW'(HALF));
                    if (per_end_c) begin
                        if (bit_q == 6'(PRE_LAST)) begin
                            state_q  <= FRAME;
                            bit_q    <= '0;
                            mdio_o_q <= sh_q[31];
                        end else begin
                            bit_q <= bit_d;
                        end
                    end
                end
                FRAME: begin
                    cnt_q <= cnt_d;
                    mdc_q <= (cnt_d >= CW'(HALF));
                    // Sample on the mdc rising cycle: TA bit 2 then DATA MSB first
                    if (rd_q && mid_c) begin
                        if (bit_q == 6'(TA2_BIT)) ta_err_q <= mdio_i;
                        if (bit_q > 6'(TA2_BIT))  rx_q     <= {rx_q[14:0], mdio_i};
                    end
                    if (per_end_c) begin
                        if (bit_q == 6'(FRAME_LAST)) begin
                            state_q   <= TAIL;
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                        end else begin
                            bit_q     <= bit_d;
                            sh_q      <= {sh_q[30:0], 1'b1};
                            mdio_oe_q <= oe_d;
                            mdio_o_q  <= oe_d ? sh_q[30] : 1'b1;
                        end
                    end
                end
                TAIL: begin
                    cnt_q <= cnt_d;
                    mdc_q <= (cnt_d >= CW'(HALF));
                    if (per_end_c) begin
                        state_q     <= IDLE;
                        mdc_q       <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rd_q ? rx_q : 16'h0000;
                        rsp_err_q   <= rd_q && ta_err_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master_22_45.sv
// Bench for mdio_master_22_45: directed vector table, random commands against a frame model,
// held-valid back-to-back traffic and a mid-frame reset.
module tb_mdio_master_22_45;
    localparam int DIV  = 10;
    localparam int PRE  = 32;
    localparam int HALF = DIV / 2;
    localparam int NP   = PRE + 33;

    logic        clk_25m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_cl45 = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_phyad = 5'h00;
    logic [4:0]  cmd_regad = 5'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_rdata_q = 16'h0000;
    logic        exp_err_q   = 1'b0;

    typedef struct {
        bit        cl45;
        bit [1:0]  op;
        bit [4:0]  phy;
        bit [4:0]  rad;
        bit [15:0] wdata;
        bit [15:0] sdata;
        bit        ta2;
        bit [31:0] exp_frame;
        bit [15:0] exp_rdata;
        bit        exp_err;
        bit        exp_illegal;
    } vec_t;

    vec_t vecs[9];

    mdio_master_22_45 #(.MDC_DIV(DIV), .PRE_LEN(PRE)) dut (
        .clk_25m  (clk_25m),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_cl45 (cmd_cl45),
        .cmd_op   (cmd_op),
        .cmd_phyad(cmd_phyad),
        .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .mdio_i   (mdio_i)
    );

    always #5 clk_25m = ~clk_25m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit model_is_read(input bit cl45, input bit [1:0] op);
        if (cl45) return (op == 2'b11) || (op == 2'b10);
        return op == 2'b10;
    endfunction

    function automatic bit model_illegal(input bit cl45, input bit [1:0] op);
        return !cl45 && ((op == 2'b00) || (op == 2'b11));
    endfunction

    // Wire image of the 32 frame bits as seen on mdio_o (released bits read back as 1)
    function automatic bit [31:0] model_frame(input bit cl45, input bit [1:0] op, input bit [4:0] phy,
                                              input bit [4:0] rad, input bit [15:0] wdata);
        bit [31:0] w;
        w = (cl45 ? 32'd0 : 32'd1) * 32'h4000_0000;
        w = w + 32'(op) * 32'h1000_0000 + 32'(phy) * 32'h0080_0000 + 32'(rad) * 32'h0004_0000;
        if (model_is_read(cl45, op)) w = w + 32'h0003_FFFF;
        else                         w = w + 32'h0002_0000 + 32'(wdata);
        return w;
    endfunction

    function automatic vec_t mk(input bit cl45, input bit [1:0] op, input bit [4:0] phy, input bit [4:0] rad,
                                input bit [15:0] wdata, input bit [15:0] sdata, input bit ta2,
                                input bit [31:0] ef, input bit [15:0] er, input bit ee, input bit ei);
        vec_t v;
        v.cl45 = cl45; v.op = op; v.phy = phy; v.rad = rad; v.wdata = wdata;
        v.sdata = sdata; v.ta2 = ta2; v.exp_frame = ef; v.exp_rdata = er;
        v.exp_err = ee; v.exp_illegal = ei;
        return v;
    endfunction

    // Issue one command at the current negedge and follow it to its response cycle
    task automatic run_cmd(input vec_t v, input bit hold);
        int e_wire, e_mdc, e_busy, e_rsp, e_hold, bad_p, f;
        bit rd, eo, eoe;
        e_wire = 0; e_mdc = 0; e_busy = 0; e_rsp = 0; e_hold = 0; bad_p = -1;
        rd = model_is_read(v.cl45, v.op);
        cmd_valid = 1'b1; cmd_cl45 = v.cl45; cmd_op = v.op;
        cmd_phyad = v.phy; cmd_regad = v.rad; cmd_wdata = v.wdata;
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk_25m);
        #1;
        if (!hold) cmd_valid = 1'b0;
        if (v.exp_illegal) begin
            @(negedge clk_25m);
            check("illegal_rsp_valid", 32'(rsp_valid), 32'd1);
            check("illegal_rsp_err", 32'(rsp_err), 32'd1);
            check("illegal_rsp_rdata", 32'(rsp_rdata), 32'd0);
            check("illegal_mdc_oe", {30'd0, mdc, mdio_oe}, 32'd0);
            check("illegal_ready", 32'(cmd_ready), 32'd1);
            exp_rdata_q = 16'h0000;
            exp_err_q   = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < DIV; k++) begin
                    @(negedge clk_25m);
                    if (hold) begin
                        cmd_cl45 = 1'($urandom); cmd_op = 2'($urandom);
                        cmd_phyad = 5'($urandom); cmd_regad = 5'($urandom); cmd_wdata = 16'($urandom);
                    end
                    f = p - PRE;
                    if (k == 0) begin
                        if (rd && f == 15)                 mdio_i = v.ta2;
                        else if (rd && f >= 16 && f <= 31) mdio_i = v.sdata[4'(31 - f)];
                        else                               mdio_i = 1'b1;
                    end
                    if (f < 0)       begin eo = 1'b1; eoe = 1'b1; end
                    else if (f < 32) begin
                        eoe = !rd || (f < 14);
                        eo  = eoe ? v.exp_frame[5'(31 - f)] : 1'b1;
                    end else         begin eo = 1'b1; eoe = 1'b0; end
                    if (mdio_o !== eo || mdio_oe !== eoe) begin
                        e_wire++;
                        if (bad_p < 0) bad_p = p;
                    end
                    if (mdc !== ((k >= HALF) ? 1'b1 : 1'b0)) e_mdc++;
                    if (busy !== 1'b1 || cmd_ready !== 1'b0) e_busy++;
                    if (rsp_valid !== 1'b0) e_rsp++;
                    if (rsp_rdata !== exp_rdata_q || rsp_err !== exp_err_q) e_hold++;
                end
            end
            check($sformatf("wire_bits first_bad_period=%0d", bad_p), 32'(e_wire), 32'd0);
            check("mdc_waveform", 32'(e_mdc), 32'd0);
            check("busy_during_frame", 32'(e_busy), 32'd0);
            check("no_early_rsp", 32'(e_rsp), 32'd0);
            check("rsp_hold", 32'(e_hold), 32'd0);
            @(negedge clk_25m);
            check("rsp_valid_at_latency", 32'(rsp_valid), 32'd1);
            check("ready_at_rsp", {30'd0, cmd_ready, busy}, 32'd2);
            check("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
            check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
            check("idle_bus", {29'd0, mdc, mdio_oe, mdio_o}, 32'd1);
            exp_rdata_q = v.exp_rdata;
            exp_err_q   = v.exp_err;
        end
        mdio_i = 1'b1;
    endtask

    task automatic run_abort();
        int e;
        cmd_valid = 1'b1; cmd_cl45 = 1'b0; cmd_op = 2'b01;
        cmd_phyad = 5'h07; cmd_regad = 5'h09; cmd_wdata = 16'h1357;
        @(posedge clk_25m);
        #1 cmd_valid = 1'b0;
        repeat (40 * DIV + 3) @(negedge clk_25m);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mdc_oe", {30'd0, mdc, mdio_oe}, 32'd0);
        check("abort_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
        check("abort_mdio_o", 32'(mdio_o), 32'd1);
        check("abort_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        exp_rdata_q = 16'h0000;
        exp_err_q   = 1'b0;
        @(negedge clk_25m);
        @(negedge clk_25m);
        rst_n = 1'b1;
        e = 0;
        repeat (3 * DIV) begin
            @(negedge clk_25m);
            if (rsp_valid !== 1'b0 || mdc !== 1'b0 || cmd_ready !== 1'b1) e++;
        end
        check("post_abort_quiet", 32'(e), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = mk(1'b0, 2'b01, 5'h03, 5'h1F, 16'hA5C3, 16'h0000, 1'b0, 32'h51FE_A5C3, 16'h0000, 1'b0, 1'b0);
        vecs[1] = mk(1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 16'h1234, 1'b0, 32'h608B_FFFF, 16'h1234, 1'b0, 1'b0);
        vecs[2] = mk(1'b1, 2'b00, 5'h05, 5'h1E, 16'h8000, 16'h0000, 1'b0, 32'h02FA_8000, 16'h0000, 1'b0, 1'b0);
        vecs[3] = mk(1'b1, 2'b11, 5'h05, 5'h1E, 16'h0000, 16'hBEEF, 1'b0, 32'h32FB_FFFF, 16'hBEEF, 1'b0, 1'b0);
        vecs[4] = mk(1'b0, 2'b10, 5'h1F, 5'h00, 16'h0000, 16'hFFFF, 1'b1, 32'h6F83_FFFF, 16'hFFFF, 1'b1, 1'b0);
        vecs[5] = mk(1'b0, 2'b11, 5'h04, 5'h04, 16'h1111, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b1);
        vecs[6] = mk(1'b0, 2'b00, 5'h08, 5'h10, 16'h2222, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b1);
        vecs[7] = mk(1'b1, 2'b10, 5'h00, 5'h03, 16'h0000, 16'h0F0F, 1'b0, 32'h200F_FFFF, 16'h0F0F, 1'b0, 1'b0);
        vecs[8] = mk(1'b1, 2'b01, 5'h02, 5'h01, 16'h00FF, 16'h0000, 1'b0, 32'h1106_00FF, 16'h0000, 1'b0, 1'b0);

        repeat (3) @(negedge clk_25m);
        check("reset_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
        check("reset_rsp", {14'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        check("reset_bus", {29'd0, mdc, mdio_oe, mdio_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk_25m);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], 1'b0);

        for (int i = 0; i < 10; i++) begin
            v.cl45  = 1'($urandom);
            v.op    = 2'($urandom);
            v.phy   = 5'($urandom);
            v.rad   = 5'($urandom);
            v.wdata = 16'($urandom);
            v.sdata = 16'($urandom);
            v.ta2   = ($urandom_range(0, 3) == 0);
            v.exp_illegal = model_illegal(v.cl45, v.op);
            v.exp_frame   = model_frame(v.cl45, v.op, v.phy, v.rad, v.wdata);
            v.exp_rdata   = model_is_read(v.cl45, v.op) ? v.sdata : 16'h0000;
            v.exp_err     = v.exp_illegal || (model_is_read(v.cl45, v.op) && v.ta2);
            run_cmd(v, 1'b0);
        end

        // cmd_valid stays high with scrambled fields; next command taken in the rsp cycle
        run_cmd(vecs[3], 1'b1);
        run_cmd(vecs[0], 1'b1);
        run_cmd(vecs[1], 1'b0);

        run_abort();
        run_cmd(vecs[7], 1'b0);

        cmd_valid = 1'b0;
        repeat (5) @(negedge clk_25m);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
